jk_bank_arbiter: RTL and testbench
==================================

// Module: jk_bank_arbiter
// PURPOSE
//  Shares one bank of WIDTH JK flip-flop cells among N_REQ requesters.
//  Each requester posts a JK command (hold/clear/set/toggle) plus a bit mask over a valid/ready handshake.
//  A round-robin arbiter serialises the requests. A 3-state FSM then applies exactly one winning command per transaction.
//  Sits between control agents and the shared status/flag register bank; q is the bank state.
// PARAMETERS
//  WIDTH  8  number of JK cells in the bank (>=1)
//  N_REQ  4  number of requesters (>=2); IDW = $clog2(N_REQ)
// PORTS
//  clk        in   1            rising-edge clock; sole clock domain
//  reset      in   1            synchronous, active-low reset (sampled on posedge clk)
//  req_valid  in   N_REQ        requester i has a command pending
//  req_cmd    in   2*N_REQ      {j,k} for requester i at [2i+1:2i]
//  req_mask   in   WIDTH*N_REQ  cells affected by requester i at [WIDTH*i +: WIDTH]
//  req_ready  out  N_REQ        one-cycle completion pulse to the winning requester
//  q          out  WIDTH        JK bank state
//  busy       out  1            high in APPLY and ACK
//  grant_id   out  IDW          index of current/last winner
// BEHAVIOUR
//  Reset (reset==0 at posedge): q=0, req_ready=0, busy=0, grant_id=0, rr_ptr=0, state=IDLE.
//   An in-flight command is discarded and never applied; the requester keeps valid and is re-arbitrated.
//  FSM:
//   IDLE -> APPLY when |req_valid.
//     Winner = first i with req_valid[i], scanning from rr_ptr upward with wrap-around.
//     Latch cmd/mask/id in that cycle; grant_id updates.
//   APPLY -> ACK unconditionally.
//     Drive the latched {j,k} to the cells where mask=1; all other cells get {0,0} (hold).
//     q updates at the end of APPLY.
//   ACK -> IDLE.
//     req_ready[winner]=1 for exactly this cycle; rr_ptr <= (winner+1) mod N_REQ.
//  Latency: valid seen in IDLE at cycle T -> q updated at T+2 edge -> ready high during T+2 -> next grant at T+3 earliest.
//  Handshake: requester holds valid/cmd/mask stable until its ready pulse, then may drop or post a new command.
//   Values are latched at the grant, so later changes before ready do not affect the applied command.
//   A requester dropping valid before its grant is simply skipped.
//  Cell semantics (per bit, mask=1): 00 hold, 01 clear, 10 set, 11 toggle.
//  Boundaries:
//   - mask=0: a full transaction still occurs and ready still pulses; q is unchanged.
//   - Single requester streaming: served every 3 cycles.
//   - rr_ptr wrap: N_REQ-1 -> 0.
//   - All requesters valid: grants follow rr order with no starvation.
//  At most one req_ready bit is high at a time; req_ready is never high outside ACK.
// CONFIGURATION
//  JKB_PRIORITY0_EN defined:
//   Requester 0 wins whenever req_valid[0] is high in IDLE, regardless of rr_ptr.
//   rr_ptr is not updated after a requester-0 grant. Other grants follow round-robin.
//  JKB_PRIORITY0_EN undefined: pure round-robin over all requesters.
// STRUCTURE
//  Package jk_bank_pkg:
//   - typedef enum logic[1:0] jk_cmd_e {JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11}
//   - typedef enum logic[1:0] jkb_state_e {S_IDLE, S_APPLY, S_ACK}
//  Sub-module jk_cell: one JK flop with synchronous active-low reset, ports (clk, reset, j, k, q).
//   Instantiated WIDTH times via generate.
//  Arbiter (rr scan) and FSM live in jk_bank_arbiter.
// TESTING (WIDTH=8, N_REQ=4 unless noted)
//  1. Reset low 2 cycles, then high -> q=8'h00, req_ready=0, busy=0, grant_id=0.
//  2. Req1 SET mask=8'h0F, then after its ready Req1 TGL mask=8'hFF
//     -> q=8'h0F after first ready, q=8'hF0 after second; each ready pulse lasts 1 cycle.
//  3. All four valid with SET and masks 01,02,04,08 -> grant order 0,1,2,3 at 3-cycle spacing; final q=8'h0F.
//  4. With rr_ptr=2, only req0 and req3 valid -> req3 granted first, then req0 (wrap).
//  5. Reset driven low during APPLY of Req2 SET mask=8'hFF
//     -> q stays 8'h00, no ready pulse; Req2 is granted again after reset releases.
//  6. JKB_PRIORITY0_EN, req0 continuously valid plus req2 -> req0 wins every transaction.
//     Without the macro -> alternates 0,2,0,2.

Source files
------------

// File: rtl/jk_bank_pkg.sv
// Shared types for the JK bank arbiter: cell command encoding, FSM states
// and the per-cell JK next-state rule.
package jk_bank_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_ACK
    } jkb_state_e;

    function automatic logic jk_next(logic q, jk_cmd_e cmd);
        logic r;
        r = q;
        case (cmd)
            JK_CLR:  r = 1'b0;
            JK_SET:  r = 1'b1;
            JK_TGL:  r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell of the shared bank, synchronous active-low reset.
module jk_cell
    import jk_bank_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            q <= jk_next(q, jk_cmd_e'({j, k}));
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that applies one requester's JK command to a shared bank
// per IDLE/APPLY/ACK transaction. Define JKB_PRIORITY0_EN to give requester 0 priority.
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    localparam int IDW = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [2*N_REQ-1:0]     req_cmd,
    input  logic [WIDTH*N_REQ-1:0] req_mask,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       q,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id
);

    jkb_state_e       state;
    jkb_state_e       state_next;
    logic             any_valid;
    logic             win_found;
    int               scan_idx;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   rr_ptr_next;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   lat_id;
    jk_cmd_e          win_cmd;
    jk_cmd_e          lat_cmd;
    logic [WIDTH-1:0] win_mask;
    logic [WIDTH-1:0] lat_mask;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;

    assign any_valid = |req_valid;
    assign grant_id  = lat_id;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (any_valid) state_next = S_APPLY;
            S_APPLY: state_next = S_ACK;
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Scan from rr_ptr upward with wrap-around; the first valid requester wins.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        scan_idx  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            if (!win_found && req_valid[IDW'(scan_idx)]) begin
                win_id    = IDW'(scan_idx);
                win_found = 1'b1;
            end
        end
`ifdef JKB_PRIORITY0_EN
        if (req_valid[0]) begin
            win_id = '0;
        end
`endif
    end

    always_comb begin
        win_cmd  = JK_HOLD;
        win_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == IDW'(i)) begin
                win_cmd  = jk_cmd_e'(req_cmd[2*i +: 2]);
                win_mask = req_mask[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        rr_ptr_next = (lat_id == IDW'(N_REQ - 1)) ? '0 : lat_id + IDW'(1);
`ifdef JKB_PRIORITY0_EN
        if (lat_id == '0) begin
            rr_ptr_next = rr_ptr;
        end
`endif
    end

    // The command is captured at the grant so the requester's later edits cannot leak in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_id   <= '0;
            lat_cmd  <= JK_HOLD;
            lat_mask <= '0;
            rr_ptr   <= '0;
        end else begin
            if (state == S_IDLE && any_valid) begin
                lat_id   <= win_id;
                lat_cmd  <= win_cmd;
                lat_mask <= win_mask;
            end
            if (state == S_ACK) begin
                rr_ptr <= rr_ptr_next;
            end
        end
    end

    always_comb begin
        busy      = 1'b0;
        req_ready = '0;
        cell_j    = '0;
        cell_k    = '0;
        case (state)
            S_APPLY: begin
                busy   = 1'b1;
                cell_j = (lat_cmd == JK_SET || lat_cmd == JK_TGL) ? lat_mask : '0;
                cell_k = (lat_cmd == JK_CLR || lat_cmd == JK_TGL) ? lat_mask : '0;
            end
            S_ACK: begin
                busy = 1'b1;
                for (int i = 0; i < N_REQ; i++) begin
                    req_ready[i] = (lat_id == IDW'(i));
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (cell_j[b]),
            .k     (cell_k[b]),
            .q     (q[b])
        );
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(req_ready));

    a_ready_in_ack: assert property (@(posedge clk) disable iff (!reset)
        (req_ready != '0) |-> (state == S_ACK));

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a transaction-level model.
module tb_jk_bank_arbiter;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;
    localparam int IDW   = 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [2*N_REQ-1:0]     req_cmd = '0;
    logic [WIDTH*N_REQ-1:0] req_mask = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]       q;
    logic                   busy;
    logic [IDW-1:0]         grant_id;

    int checks = 0;
    int failures = 0;

    logic       pend  [N_REQ];
    logic [1:0] pcmd  [N_REQ];
    logic [7:0] pmask [N_REQ];
    logic [7:0] mq;
    int         mptr;
    int         last_win;

    typedef struct {
        int         req;
        logic [1:0] cmd;
        logic [7:0] mask;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[9];

    jk_bank_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .req_mask  (req_mask),
        .req_ready (req_ready),
        .q         (q),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Model: winner is the first pending requester at or after the pointer, modulo N_REQ.
    function automatic int model_pick(logic [N_REQ-1:0] v, int ptr);
`ifdef JKB_PRIORITY0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_apply(logic [7:0] cur, logic [1:0] cmd, logic [7:0] m);
        case (cmd)
            2'b01:   return cur & ~m;
            2'b10:   return cur | m;
            2'b11:   return cur ^ m;
            default: return cur;
        endcase
    endfunction

    function automatic int model_next_ptr(int w, int ptr);
`ifdef JKB_PRIORITY0_EN
        if (w == 0) return ptr;
`endif
        return (w + 1) % N_REQ;
    endfunction

    function automatic logic [N_REQ-1:0] pend_vec();
        logic [N_REQ-1:0] v;
        for (int i = 0; i < N_REQ; i++) v[i] = pend[i];
        return v;
    endfunction

    task automatic applyStimulus();
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i]                = pend[i];
            req_cmd[2*i +: 2]           = pcmd[i];
            req_mask[WIDTH*i +: WIDTH]  = pmask[i];
        end
    endtask

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic clear_pending();
        for (int i = 0; i < N_REQ; i++) begin
            pend[i]  = 1'b0;
            pcmd[i]  = 2'b00;
            pmask[i] = 8'h00;
        end
        applyStimulus();
    endtask

    task automatic do_reset();
        clear_pending();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mq   = 8'h00;
        mptr = 0;
    endtask

    task automatic check_idle(string tag);
        @(negedge clk);
        checkOutput({tag, "_q"}, q, 8'h00);
        checkOutput({tag, "_ready"}, req_ready, 4'h0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_grant_id"}, grant_id, 2'd0);
    endtask

    task automatic wait_ready(output int id, output int cycles);
        id = -1;
        cycles = 0;
        while (id < 0 && cycles < 12) begin
            @(negedge clk);
            cycles++;
            if (req_ready != '0) begin
                checkOutput("ready_onehot", $countones(req_ready), 1);
                for (int i = N_REQ - 1; i >= 0; i--) begin
                    if (req_ready[i]) id = i;
                end
            end
        end
        if (id < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL ready_timeout: got no ready within %0d cycles expected a pulse", cycles);
        end
    endtask

    task automatic serve_expect(string tag, int w, logic [7:0] eq, int exp_lat);
        int id;
        int cyc;
        wait_ready(id, cyc);
        if (id >= 0) begin
            checkOutput({tag, "_winner"}, id, w);
            checkOutput({tag, "_q"}, q, eq);
            checkOutput({tag, "_grant_id"}, grant_id, w);
            checkOutput({tag, "_busy"}, busy, 1'b1);
            checkOutput({tag, "_latency"}, cyc, exp_lat);
        end
    endtask

    // Must be called at the start of an IDLE cycle with at least one request pending.
    task automatic serve_next(string tag, bit keep, bit scramble);
        int w;
        logic [7:0] eq;
        w  = model_pick(pend_vec(), mptr);
        eq = model_apply(mq, pcmd[w], pmask[w]);
        mq = eq;
        mptr = model_next_ptr(w, mptr);
        last_win = w;
        if (scramble) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (pend[i]) begin
                    pcmd[i]  = 2'($urandom_range(3, 0));
                    pmask[i] = 8'($urandom);
                end
            end
            applyStimulus();
        end
        serve_expect(tag, w, eq, scramble ? 2 : 3);
        @(posedge clk);
        #1;
        if (!keep) pend[w] = 1'b0;
        applyStimulus();
    endtask

    initial begin
        int exp_seq[4];

        vecs[0] = '{1, 2'b10, 8'h0F, 8'h0F};
        vecs[1] = '{1, 2'b11, 8'hFF, 8'hF0};
        vecs[2] = '{3, 2'b01, 8'h30, 8'hC0};
        vecs[3] = '{0, 2'b10, 8'h03, 8'hC3};
        vecs[4] = '{2, 2'b00, 8'hFF, 8'hC3};
        vecs[5] = '{2, 2'b11, 8'h00, 8'hC3};
        vecs[6] = '{0, 2'b11, 8'h81, 8'h42};
        vecs[7] = '{3, 2'b10, 8'hFF, 8'hFF};
        vecs[8] = '{1, 2'b01, 8'h5A, 8'hA5};

        $display("[TB] reset and directed vectors");
        do_reset();
        check_idle("reset0");
        @(posedge clk);
        #1;
        for (int n = 0; n < 9; n++) begin
            pend[vecs[n].req]  = 1'b1;
            pcmd[vecs[n].req]  = vecs[n].cmd;
            pmask[vecs[n].req] = vecs[n].mask;
            applyStimulus();
            serve_expect($sformatf("vec%0d", n), vecs[n].req, vecs[n].exp_q, 3);
            @(posedge clk);
            #1;
            pend[vecs[n].req] = 1'b0;
            applyStimulus();
            @(negedge clk);
            checkOutput($sformatf("vec%0d_ready_drop", n), req_ready, 4'h0);
            checkOutput($sformatf("vec%0d_busy_drop", n), busy, 1'b0);
            @(posedge clk);
            #1;
        end

        $display("[TB] all four requesters");
        do_reset();
        check_idle("reset1");
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            pend[i]  = 1'b1;
            pcmd[i]  = 2'b10;
            pmask[i] = 8'(1 << i);
        end
        applyStimulus();
        for (int k = 0; k < N_REQ; k++) begin
            serve_next($sformatf("all%0d", k), 1'b0, 1'b0);
            checkOutput($sformatf("all%0d_order", k), last_win, k);
        end
        checkOutput("all_final_q", q, 8'h0F);

        $display("[TB] pointer wrap");
        pend[1] = 1'b1; pcmd[1] = 2'b01; pmask[1] = 8'hFF;
        applyStimulus();
        serve_next("wrap_setup", 1'b0, 1'b0);
        pend[0] = 1'b1; pcmd[0] = 2'b10; pmask[0] = 8'h10;
        pend[3] = 1'b1; pcmd[3] = 2'b10; pmask[3] = 8'h80;
        applyStimulus();
`ifdef JKB_PRIORITY0_EN
        exp_seq[0] = 0; exp_seq[1] = 3;
`else
        exp_seq[0] = 3; exp_seq[1] = 0;
`endif
        for (int k = 0; k < 2; k++) begin
            serve_next($sformatf("wrap%0d", k), 1'b0, 1'b0);
            checkOutput($sformatf("wrap%0d_order", k), last_win, exp_seq[k]);
        end
        checkOutput("wrap_final_q", q, 8'h90);

        $display("[TB] reset during APPLY");
        do_reset();
        @(posedge clk);
        #1;
        pend[2] = 1'b1; pcmd[2] = 2'b10; pmask[2] = 8'hFF;
        applyStimulus();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rstapply_busy_before", busy, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        mq = 8'h00;
        mptr = 0;
        check_idle("rstapply");
        serve_expect("rstapply_regrant", 2, 8'hFF, 2);
        @(posedge clk);
        #1;
        pend[2] = 1'b0;
        applyStimulus();
        mq = 8'hFF;
        mptr = 3;

        $display("[TB] req0 and req2 continuously valid");
        do_reset();
        @(posedge clk);
        #1;
        pend[0] = 1'b1; pcmd[0] = 2'b11; pmask[0] = 8'h01;
        pend[2] = 1'b1; pcmd[2] = 2'b11; pmask[2] = 8'h04;
        applyStimulus();
`ifdef JKB_PRIORITY0_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 2, 0, 2};
`endif
        for (int k = 0; k < 4; k++) begin
            serve_next($sformatf("pair%0d", k), 1'b1, 1'b0);
            checkOutput($sformatf("pair%0d_order", k), last_win, exp_seq[k]);
        end

        $display("[TB] randomized traffic");
        do_reset();
        @(posedge clk);
        #1;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i]  = 1'b1;
                    pcmd[i]  = 2'($urandom_range(3, 0));
                    pmask[i] = 8'($urandom);
                end else if (pend[i] && $urandom_range(7, 0) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            if (pend_vec() == '0) begin
                pend[it % N_REQ]  = 1'b1;
                pcmd[it % N_REQ]  = 2'($urandom_range(3, 0));
                pmask[it % N_REQ] = 8'($urandom);
            end
            applyStimulus();
            serve_next($sformatf("rnd%0d", it), 1'b0, $urandom_range(1, 0) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
